// File: rtl/phys_reg_file.sv
// Physical register file for the out-of-order core: combinational multi-port reads with
// optional write bypass, per-register ready bits for wakeup, and a sticky write-collision flag.
module phys_reg_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PREGS   = 64,
  parameter int ADDR_WIDTH  = $clog2(NUM_PREGS),
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ALLOC_PORTS = 2,
  parameter int BYPASS      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]   read_addrs,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   read_data,
  output logic [READ_PORTS-1:0]                   read_ready,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  write_addrs,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  write_data,
  input  logic [WRITE_PORTS-1:0]                  write_reg_enable,
  input  logic [ALLOC_PORTS-1:0][ADDR_WIDTH-1:0]  alloc_addrs,
  input  logic [ALLOC_PORTS-1:0]                  alloc_valid,
  input  logic                                    flush,
  output logic                                    conflict_err
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_PREGS];
  logic [NUM_PREGS-1:0]  r_ready;
  logic                  r_conflict_err;
  logic                  w_conflict;

  // p0 is hardwired and addresses beyond NUM_PREGS do not exist.
  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) != 0) && (int'(a) < NUM_PREGS);
  endfunction

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < READ_PORTS; k++) begin
      read_data[k]  = '0;
      read_ready[k] = 1'b0;
      if (read_addrs[k] == '0) begin
        read_ready[k] = 1'b1;
      end else if (f_in_range(read_addrs[k])) begin
        read_data[k]  = r_regs[read_addrs[k]];
        read_ready[k] = r_ready[read_addrs[k]];
        if (BYPASS != 0) begin
          // Ascending scan: the highest-index matching write port wins.
          for (int j = 0; j < WRITE_PORTS; j++) begin
            if (write_reg_enable[j] && (write_addrs[j] == read_addrs[k])) begin
              read_data[k]  = write_data[j];
              read_ready[k] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      for (int m = j + 1; m < WRITE_PORTS; m++) begin
        if (write_reg_enable[j] && write_reg_enable[m] &&
            (write_addrs[j] == write_addrs[m]) && (write_addrs[j] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments; later assignments in this block override
  // earlier ones, which encodes the flush > alloc > write priority on each ready bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset because architectural state must start at zero;
      // this rules out a plain RAM macro for r_regs.
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_ready        <= '1;
      r_conflict_err <= 1'b0;
    end else begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (write_reg_enable[j] && f_in_range(write_addrs[j])) begin
          r_regs[write_addrs[j]]  <= write_data[j];
          r_ready[write_addrs[j]] <= 1'b1;
        end
      end
      if (flush) begin
        r_ready <= '1;
      end else begin
        for (int i = 0; i < ALLOC_PORTS; i++) begin
          if (alloc_valid[i] && f_in_range(alloc_addrs[i])) begin
            r_ready[alloc_addrs[i]] <= 1'b0;
          end
        end
      end
      if (w_conflict) begin
        r_conflict_err <= 1'b1;
      end
    end
  end

  assign conflict_err = r_conflict_err;

endmodule

// File: tb/tb_phys_reg_file.sv
// Scoreboard bench for phys_reg_file: a bypassing 64-entry instance and a non-bypassing
// 48-entry instance; stimulus queues expected read values, a negedge monitor compares them.
module tb_phys_reg_file;

  logic clk;
  logic rst;

  // Instance A: defaults (64 regs, bypass on)
  logic [3:0][5:0]  rd_addr_a;
  logic [3:0][31:0] rd_data_a;
  logic [3:0]       rd_rdy_a;
  logic [1:0][5:0]  wr_addr_a;
  logic [1:0][31:0] wr_data_a;
  logic [1:0]       wr_en_a;
  logic [1:0][5:0]  al_addr_a;
  logic [1:0]       al_vld_a;
  logic             flush_a;
  logic             err_a;

  // Instance B: 48 regs, bypass off
  logic [3:0][5:0]  rd_addr_b;
  logic [3:0][31:0] rd_data_b;
  logic [3:0]       rd_rdy_b;
  logic [1:0][5:0]  wr_addr_b;
  logic [1:0][31:0] wr_data_b;
  logic [1:0]       wr_en_b;
  logic [1:0][5:0]  al_addr_b;
  logic [1:0]       al_vld_b;
  logic             flush_b;
  logic             err_b;

  phys_reg_file u_dut_a (
    .clk(clk), .rst(rst),
    .read_addrs(rd_addr_a), .read_data(rd_data_a), .read_ready(rd_rdy_a),
    .write_addrs(wr_addr_a), .write_data(wr_data_a), .write_reg_enable(wr_en_a),
    .alloc_addrs(al_addr_a), .alloc_valid(al_vld_a),
    .flush(flush_a), .conflict_err(err_a)
  );

  phys_reg_file #(.NUM_PREGS(48), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .read_addrs(rd_addr_b), .read_data(rd_data_b), .read_ready(rd_rdy_b),
    .write_addrs(wr_addr_b), .write_data(wr_data_b), .write_reg_enable(wr_en_b),
    .alloc_addrs(al_addr_b), .alloc_valid(al_vld_b),
    .flush(flush_b), .conflict_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          dut;
    int          port;
    bit          is_err;
    logic [31:0] d;
    logic        r;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.is_err) begin
        check(e.name, (e.dut == 0) ? 32'(err_a) : 32'(err_b), 32'(e.r));
      end else if (e.dut == 0) begin
        check({e.name, ".data"}, rd_data_a[e.port], e.d);
        check({e.name, ".rdy"}, 32'(rd_rdy_a[e.port]), 32'(e.r));
      end else begin
        check({e.name, ".data"}, rd_data_b[e.port], e.d);
        check({e.name, ".rdy"}, 32'(rd_rdy_b[e.port]), 32'(e.r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_a = '0; al_vld_a = '0; flush_a = 1'b0;
    wr_en_b = '0; al_vld_b = '0; flush_b = 1'b0;
  endtask

  task automatic rd(input int dut, input int k, input logic [5:0] a,
                    input logic [31:0] d, input logic r, input string name);
    exp_t x;
    if (dut == 0) rd_addr_a[k] = a;
    else          rd_addr_b[k] = a;
    x.name = name; x.dut = dut; x.port = k; x.is_err = 1'b0; x.d = d; x.r = r;
    q.push_back(x);
  endtask

  task automatic exp_err(input int dut, input logic r, input string name);
    exp_t x;
    x.name = name; x.dut = dut; x.port = 0; x.is_err = 1'b1; x.d = '0; x.r = r;
    q.push_back(x);
  endtask

  task automatic wr_a(input int j, input logic [5:0] a, input logic [31:0] d);
    wr_en_a[j] = 1'b1; wr_addr_a[j] = a; wr_data_a[j] = d;
  endtask

  task automatic wr_b(input int j, input logic [5:0] a, input logic [31:0] d);
    wr_en_b[j] = 1'b1; wr_addr_b[j] = a; wr_data_b[j] = d;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_a = '0; wr_addr_a = '0; wr_data_a = '0; al_addr_a = '0;
    rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0; al_addr_b = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every address reads data 0, ready 1.
    for (int a = 0; a < 64; a += 4) begin
      for (int k = 0; k < 4; k++) rd(0, k, 6'(a + k), 32'h0, 1'b1, $sformatf("reset_p%0d", a + k));
      tick();
    end
    exp_err(0, 1'b0, "reset_err");
    tick();

    // Alloc clears ready; write bypasses then commits.
    al_vld_a[0] = 1'b1; al_addr_a[0] = 6'd5;
    tick();
    idle();
    rd(0, 0, 6'd5, 32'h0, 1'b0, "alloc_p5");
    tick();
    wr_a(0, 6'd5, 32'hDEAD);
    rd(0, 2, 6'd5, 32'hDEAD, 1'b1, "bypass_p5");
    tick();
    idle();
    rd(0, 2, 6'd5, 32'hDEAD, 1'b1, "state_p5");
    tick();

    // Write collision: higher port wins, flag is sticky across idle and flush.
    wr_a(0, 6'd9, 32'h11);
    wr_a(1, 6'd9, 32'h22);
    rd(0, 1, 6'd9, 32'h22, 1'b1, "coll_bypass_p9");
    exp_err(0, 1'b0, "coll_err_pre");
    tick();
    idle();
    rd(0, 1, 6'd9, 32'h22, 1'b1, "coll_state_p9");
    exp_err(0, 1'b1, "coll_err_set");
    for (int i = 0; i < 5; i++) tick();
    exp_err(0, 1'b1, "coll_err_idle");
    flush_a = 1'b1;
    tick();
    idle();
    exp_err(0, 1'b1, "coll_err_flush");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err(0, 1'b0, "coll_err_rst");
    rd(0, 1, 6'd9, 32'h0, 1'b1, "rst_clears_p9");
    tick();

    // Write + alloc same register: data lands, ready ends 0. Flush drops alloc.
    wr_a(0, 6'd7, 32'h33);
    al_vld_a[0] = 1'b1; al_addr_a[0] = 6'd7;
    rd(0, 0, 6'd7, 32'h33, 1'b1, "wa_bypass_p7");
    tick();
    idle();
    rd(0, 0, 6'd7, 32'h33, 1'b0, "wa_state_p7");
    tick();
    flush_a = 1'b1;
    al_vld_a[1] = 1'b1; al_addr_a[1] = 6'd8;
    tick();
    idle();
    rd(0, 0, 6'd7, 32'h33, 1'b1, "flush_p7");
    rd(0, 1, 6'd8, 32'h0, 1'b1, "flush_p8");
    tick();

    // p0 ignores writes and never bypasses.
    wr_a(0, 6'd0, 32'hFFFF);
    rd(0, 3, 6'd0, 32'h0, 1'b1, "p0_same");
    tick();
    idle();
    rd(0, 3, 6'd0, 32'h0, 1'b1, "p0_next");
    tick();

    // Reset in the same cycle as a write and alloc discards both.
    wr_a(0, 6'd3, 32'h77);
    al_vld_a[0] = 1'b1; al_addr_a[0] = 6'd4;
    tick();
    idle();
    rd(0, 0, 6'd3, 32'h77, 1'b1, "pre_rst_p3");
    rd(0, 1, 6'd4, 32'h0, 1'b0, "pre_rst_p4");
    tick();
    rst = 1'b1;
    wr_a(0, 6'd3, 32'h44);
    al_vld_a[0] = 1'b1; al_addr_a[0] = 6'd4;
    tick();
    rst = 1'b0;
    idle();
    rd(0, 0, 6'd3, 32'h0, 1'b1, "post_rst_p3");
    rd(0, 1, 6'd4, 32'h0, 1'b1, "post_rst_p4");
    tick();

    // Instance B: out-of-range address and no forwarding.
    wr_b(0, 6'd50, 32'hABC);
    rd(1, 0, 6'd50, 32'h0, 1'b0, "oor_same_p50");
    rd(1, 1, 6'd47, 32'h0, 1'b1, "top_p47");
    tick();
    idle();
    rd(1, 0, 6'd50, 32'h0, 1'b0, "oor_next_p50");
    tick();
    wr_b(0, 6'd47, 32'h99);
    wr_b(1, 6'd6, 32'h55);
    rd(1, 0, 6'd6, 32'h0, 1'b1, "nobyp_same_p6");
    rd(1, 1, 6'd47, 32'h0, 1'b1, "nobyp_same_p47");
    tick();
    idle();
    al_vld_b[0] = 1'b1; al_addr_b[0] = 6'd6;
    rd(1, 0, 6'd6, 32'h55, 1'b1, "nobyp_next_p6");
    rd(1, 1, 6'd47, 32'h99, 1'b1, "nobyp_next_p47");
    tick();
    idle();
    rd(1, 0, 6'd6, 32'h55, 1'b0, "b_alloc_p6");
    exp_err(1, 1'b0, "b_err");
    tick();

    tick();
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
